// File: rtl/quad_encoder_bank_pkg.sv
// Shared definitions for the quadrature encoder bank: direction codes, the forward
// Gray sequence on {A,B}, and the step classification used by every channel.
package quad_encoder_bank_pkg;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  localparam logic [1:0] GRAY_S0 = 2'b00;
  localparam logic [1:0] GRAY_S1 = 2'b10;
  localparam logic [1:0] GRAY_S2 = 2'b11;
  localparam logic [1:0] GRAY_S3 = 2'b01;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ILL  = 2'd3
  } step_t;

  function automatic logic [1:0] gray_fwd_next(input logic [1:0] ab);
    case (ab)
      GRAY_S0: return GRAY_S1;
      GRAY_S1: return GRAY_S2;
      GRAY_S2: return GRAY_S3;
      default: return GRAY_S0;
    endcase
  endfunction

  function automatic step_t decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    if (prev_ab == cur_ab)
      return STEP_NONE;
    else if (cur_ab == gray_fwd_next(prev_ab))
      return STEP_FWD;
    else if (prev_ab == gray_fwd_next(cur_ab))
      return STEP_REV;
    else
      return STEP_ILL;
  endfunction

endpackage

// File: rtl/quad_enc_channel.sv
// One encoder channel: 2-flop sync and glitch filter per pin, registered x4 decode,
// signed position counter with optional saturation, last direction and sticky error.
module quad_enc_channel
  import quad_encoder_bank_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 3,
  parameter int SATURATE = 0
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    cnt_clr,
  input  logic                    err_clr,
  output logic signed [CNT_W-1:0] count,
  output logic                    dir,
  output logic                    err
);

  localparam int FC_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_LEN - 1);
  localparam logic signed [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};

  logic [1:0] w_raw;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] w_filt;
  logic [1:0] r_prev_ab;
  step_t      w_step;
  step_t      r_step;
  logic signed [CNT_W-1:0] r_count;
  logic signed [CNT_W-1:0] w_cnt_next;
  logic       r_dir;
  logic       r_err;

  assign w_raw = {enc_a, enc_b};

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Bit 1 is A, bit 0 is B; each pin owns its own stability counter.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pin
      logic [FC_W-1:0] r_fcnt;
      logic            r_filt;

      always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
          r_fcnt <= '0;
          r_filt <= 1'b0;
        end else if (r_sync2[gi] == r_filt) begin
          r_fcnt <= '0;
        end else if (r_fcnt == FC_LAST) begin
          r_filt <= r_sync2[gi];
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + FC_W'(1);
        end
      end

      assign w_filt[gi] = r_filt;
    end
  endgenerate

  assign w_step = decode_step(r_prev_ab, w_filt);

  always_comb begin
    w_cnt_next = r_count;
    case (r_step)
      STEP_FWD: if (!(SATURATE != 0 && r_count == CNT_MAX)) w_cnt_next = r_count + CNT_W'(1);
      STEP_REV: if (!(SATURATE != 0 && r_count == CNT_MIN)) w_cnt_next = r_count - CNT_W'(1);
      default:  w_cnt_next = r_count;
    endcase
  end

  // A clear drops any coincident step entirely; a new illegal step beats err_clr.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_prev_ab <= '0;
      r_step    <= STEP_NONE;
      r_count   <= '0;
      r_dir     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_prev_ab <= w_filt;
      r_step    <= w_step;
      if (cnt_clr) begin
        r_count <= '0;
      end else begin
        r_count <= w_cnt_next;
        if (r_step == STEP_FWD)
          r_dir <= DIR_FWD;
        else if (r_step == STEP_REV)
          r_dir <= DIR_REV;
      end
      if (r_step == STEP_ILL)
        r_err <= 1'b1;
      else if (err_clr)
        r_err <= 1'b0;
    end
  end

  assign count = r_count;
  assign dir   = r_dir;
  assign err   = r_err;

endmodule

// File: rtl/quad_encoder_bank.sv
// Bank of N_CH quadrature decoders with an atomic snapshot array and a registered
// read mux; selects beyond the last channel read as zero.
module quad_encoder_bank
  import quad_encoder_bank_pkg::*;
#(
  parameter int N_CH     = 3,
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 3,
  parameter int SATURATE = 0,
  localparam int SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic [N_CH-1:0]         enc_a,
  input  logic [N_CH-1:0]         enc_b,
  input  logic [N_CH-1:0]         cnt_clr,
  input  logic [N_CH-1:0]         err_clr,
  input  logic                    snap,
  input  logic [SEL_W-1:0]        rd_sel,
  output logic signed [CNT_W-1:0] rd_count,
  output logic [N_CH-1:0]         dir,
  output logic [N_CH-1:0]         err
);

  localparam int N_TBL = 2 ** SEL_W;

  logic signed [CNT_W-1:0] w_count  [N_CH];
  logic signed [CNT_W-1:0] w_rd_tbl [N_TBL];
  logic signed [CNT_W-1:0] r_rd_count;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic signed [CNT_W-1:0] r_shadow;

      quad_enc_channel #(
        .CNT_W   (CNT_W),
        .FILT_LEN(FILT_LEN),
        .SATURATE(SATURATE)
      ) u_chan (
        .clk    (clk),
        .resetb (resetb),
        .enc_a  (enc_a[gi]),
        .enc_b  (enc_b[gi]),
        .cnt_clr(cnt_clr[gi]),
        .err_clr(err_clr[gi]),
        .count  (w_count[gi]),
        .dir    (dir[gi]),
        .err    (err[gi])
      );

      // Shadow sees the live value before this edge, so a coincident step or clear is excluded.
      always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)
          r_shadow <= '0;
        else if (snap)
          r_shadow <= w_count[gi];
      end

      assign w_rd_tbl[gi] = r_shadow;
    end

    for (gi = N_CH; gi < N_TBL; gi++) begin : g_pad
      assign w_rd_tbl[gi] = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)
      r_rd_count <= '0;
    else
      r_rd_count <= w_rd_tbl[rd_sel];
  end

  assign rd_count = r_rd_count;

endmodule

// File: tb/tb_quad_encoder_bank.sv
// Scoreboard bench: stimulus pushes hand-computed expectations tagged with the cycle
// at which they become observable; a negedge monitor pops and compares them.
module tb_quad_encoder_bank;

  localparam int K_RD   = 0;
  localparam int K_DIR  = 1;
  localparam int K_ERR  = 2;
  localparam int K_RDW8 = 3;
  localparam int K_RDS8 = 4;
  localparam int K_ERRV = 5;
  localparam int K_DIRV = 6;

  typedef struct {
    int    due;
    int    kind;
    int    ch;
    int    exp;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic resetb;
  logic [2:0] enc_a, enc_b, cnt_clr, err_clr;
  logic snap;
  logic [1:0] rd_sel;
  logic signed [15:0] rd_count;
  logic [2:0] dir, err;

  logic [0:0] e8_a, e8_b, clr8, zero8, sel8;
  logic snap8;
  logic signed [7:0] rd_w8, rd_s8;
  logic [0:0] dir_w8, err_w8, dir_s8, err_s8;

  logic [1:0] pos [3];
  logic [1:0] pos8;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   rd_ptr = 0;
  logic finish_req = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  quad_encoder_bank #(.N_CH(3), .CNT_W(16), .FILT_LEN(3), .SATURATE(0)) dut (
    .clk(clk), .resetb(resetb), .enc_a(enc_a), .enc_b(enc_b), .cnt_clr(cnt_clr),
    .err_clr(err_clr), .snap(snap), .rd_sel(rd_sel), .rd_count(rd_count),
    .dir(dir), .err(err)
  );

  quad_encoder_bank #(.N_CH(1), .CNT_W(8), .FILT_LEN(3), .SATURATE(0)) dut_w8 (
    .clk(clk), .resetb(resetb), .enc_a(e8_a), .enc_b(e8_b), .cnt_clr(clr8),
    .err_clr(zero8), .snap(snap8), .rd_sel(sel8), .rd_count(rd_w8),
    .dir(dir_w8), .err(err_w8)
  );

  quad_encoder_bank #(.N_CH(1), .CNT_W(8), .FILT_LEN(3), .SATURATE(1)) dut_s8 (
    .clk(clk), .resetb(resetb), .enc_a(e8_a), .enc_b(e8_b), .cnt_clr(clr8),
    .err_clr(zero8), .snap(snap8), .rd_sel(sel8), .rd_count(rd_s8),
    .dir(dir_s8), .err(err_s8)
  );

  function automatic logic [1:0] g_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] g_prev(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic int actual(input int kind, input int ch);
    case (kind)
      K_RD:    return int'(rd_count);
      K_DIR:   return int'(dir[ch]);
      K_ERR:   return int'(err[ch]);
      K_RDW8:  return int'(rd_w8);
      K_RDS8:  return int'(rd_s8);
      K_ERRV:  return int'(err);
      K_DIRV:  return int'(dir);
      default: return -1;
    endcase
  endfunction

  // Monitor: compares every expectation whose due cycle has arrived.
  always @(negedge clk) begin
    int act;
    while (rd_ptr < sb.size() && sb[rd_ptr].due <= cyc) begin
      act = actual(sb[rd_ptr].kind, sb[rd_ptr].ch);
      n_tests++;
      if (act != sb[rd_ptr].exp) begin
        n_fail++;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", sb[rd_ptr].name, act, sb[rd_ptr].exp, cyc);
      end else begin
        $display("ok   %s: %0d (cycle %0d)", sb[rd_ptr].name, act, cyc);
      end
      rd_ptr++;
    end
    if (finish_req) begin
      while (rd_ptr < sb.size()) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: never observed, expected %0d", sb[rd_ptr].name, sb[rd_ptr].exp);
        rd_ptr++;
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic expect_at(input int due, input int kind, input int ch, input int exp, input string name);
    exp_t e;
    e.due = due; e.kind = kind; e.ch = ch; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic set_pin(input int ch, input logic [1:0] ab);
    pos[ch] = ab;
    enc_a[ch] = ab[1];
    enc_b[ch] = ab[0];
  endtask

  task automatic fwd(input int ch);
    set_pin(ch, g_next(pos[ch]));
    idle(8);
  endtask

  task automatic step8(input bit forward);
    pos8 = forward ? g_next(pos8) : g_prev(pos8);
    e8_a[0] = pos8[1];
    e8_b[0] = pos8[0];
    idle(8);
  endtask

  task automatic read_main(input int sel, input int exp, input string name);
    rd_sel = 2'(sel);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    expect_at(cyc + 1, K_RD, sel, exp, name);
    tick();
  endtask

  task automatic read8(input int exp_w, input int exp_s, input string name);
    snap8 = 1'b1;
    tick();
    snap8 = 1'b0;
    expect_at(cyc + 1, K_RDW8, 0, exp_w, {name, "_wrap"});
    expect_at(cyc + 1, K_RDS8, 0, exp_s, {name, "_sat"});
    tick();
  endtask

  initial begin
    int c0;
    resetb = 1'b0;
    enc_a = '0; enc_b = '0; cnt_clr = '0; err_clr = '0; snap = 1'b0; rd_sel = '0;
    e8_a = '0; e8_b = '0; clr8 = '0; zero8 = '0; sel8 = '0; snap8 = 1'b0;
    for (int i = 0; i < 3; i++) pos[i] = 2'b00;
    pos8 = 2'b00;

    // Reset state
    idle(2);
    expect_at(cyc, K_RD, 0, 0, "reset_rd_count");
    expect_at(cyc, K_DIRV, 0, 0, "reset_dir");
    expect_at(cyc, K_ERRV, 0, 0, "reset_err");
    expect_at(cyc, K_RDW8, 0, 0, "reset_rd_w8");
    tick();
    resetb = 1'b1;
    idle(2);

    // 1: eight forward steps on ch0
    for (int i = 0; i < 8; i++) fwd(0);
    read_main(0, 8, "t1_ch0_count");
    expect_at(cyc, K_DIR, 0, 1, "t1_dir0");
    expect_at(cyc, K_ERRV, 0, 0, "t1_err_none");

    // 2: short glitch rejected, then exact latency of an accepted edge
    enc_a[1] = 1'b1;
    idle(2);
    enc_a[1] = 1'b0;
    idle(10);
    read_main(1, 0, "t2_glitch_ignored");
    c0 = cyc;
    set_pin(1, 2'b10);
    rd_sel = 2'd1;
    snap = 1'b1;
    expect_at(c0 + 8, K_RD, 1, 0, "t2_latency_before");
    expect_at(c0 + 9, K_RD, 1, 1, "t2_latency_after");
    idle(10);
    snap = 1'b0;
    expect_at(cyc, K_DIR, 1, 1, "t2_dir1");

    // 3: illegal double transition on ch2, clear, and set-beats-clear
    set_pin(2, 2'b11);
    idle(8);
    expect_at(cyc, K_ERR, 2, 1, "t3_err2_set");
    read_main(2, 0, "t3_ch2_count_held");
    err_clr[2] = 1'b1;
    tick();
    err_clr[2] = 1'b0;
    expect_at(cyc, K_ERR, 2, 0, "t3_err2_cleared");
    c0 = cyc;
    set_pin(2, 2'b00);
    idle(6);
    err_clr[2] = 1'b1;
    tick();
    err_clr[2] = 1'b0;
    expect_at(c0 + 7, K_ERR, 2, 1, "t3_set_wins_over_clr");
    idle(2);
    err_clr[2] = 1'b1;
    tick();
    err_clr[2] = 1'b0;
    expect_at(cyc, K_ERR, 2, 0, "t3_err2_cleared_again");
    expect_at(cyc, K_DIR, 2, 0, "t3_dir2_held");

    // 5: step coinciding with snap and clear on ch0
    c0 = cyc;
    set_pin(0, g_next(pos[0]));
    idle(6);
    rd_sel = 2'd0;
    snap = 1'b1;
    cnt_clr[0] = 1'b1;
    tick();
    snap = 1'b0;
    cnt_clr[0] = 1'b0;
    expect_at(cyc + 1, K_RD, 0, 8, "t5_shadow_pre_clear");
    tick();
    idle(3);
    read_main(0, 0, "t5_live_cleared");

    // 4: 8-bit wrap vs saturate
    for (int i = 0; i < 127; i++) step8(1'b1);
    read8(127, 127, "t4_127_fwd");
    step8(1'b1);
    read8(-128, 127, "t4_128_fwd");
    clr8 = 1'b1;
    tick();
    clr8 = 1'b0;
    for (int i = 0; i < 200; i++) step8(1'b0);
    read8(56, -128, "t4_200_rev");

    // 6: asynchronous reset mid-rotation, then out-of-range select
    set_pin(2, 2'b11);
    idle(8);
    expect_at(cyc, K_ERR, 2, 1, "t6_err2_before_reset");
    read_main(1, 1, "t6_rd_before_reset");
    set_pin(0, g_next(pos[0]));
    idle(3);
    #2;
    resetb = 1'b0;
    expect_at(cyc, K_RD, 0, 0, "t6_async_rd_count");
    expect_at(cyc, K_DIRV, 0, 0, "t6_async_dir");
    expect_at(cyc, K_ERRV, 0, 0, "t6_async_err");
    for (int i = 0; i < 3; i++) set_pin(i, 2'b00);
    idle(3);
    resetb = 1'b1;
    idle(2);
    for (int i = 0; i < 3; i++) set_pin(i, 2'b10);
    idle(8);
    read_main(3, 0, "t6_sel_out_of_range");
    read_main(2, 1, "t6_ch2_after_reset");
    read_main(0, 1, "t6_ch0_after_reset");
    expect_at(cyc, K_ERRV, 0, 0, "t6_err_after_reset");

    idle(4);
    finish_req = 1'b1;
  end

endmodule
